pll_lock_supervisor: RTL

Supervises up to eight PolarFire CCC/PLL instances from the fabric side. For each channel it sequences POWERDOWN_N, waits for and filters PLL_LOCK, and re-powers the PLL automatically on lock loss or lock timeout, with a bounded number of retries. It reports per-channel status and an aggregate ALL_LOCKED that gates downstream reset release. It sits between the CCC wrapper instances and the system reset controller, clocked from a free-running reference clock that does not come from any supervised PLL.

---
 rtl/pll_sup_pkg.sv | 25 ++
 rtl/pll_lock_channel.sv | 171 +++++++++++++++++
 rtl/pll_lock_supervisor.sv | 62 ++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: channel FSM states,
// retry/loss-counter widths and the saturating loss-counter increment.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PWRDN     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FLT       = 3'd4
    } pll_state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Counter width for a terminal count of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_channel.sv
// One supervised PLL: lock synchroniser, power/lock sequencing FSM, attempt
// timer, lock filter, retry counter and saturating lock-loss counter.
module pll_lock_channel
    import pll_sup_pkg::*;
#(
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_FILTER  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_clear_fault,
    input  logic              i_pll_lock,
    output logic              o_powerdown_n,
    output logic              o_locked,
    output logic              o_fault,
    output logic [LOSS_W-1:0] o_loss_cnt
);

    localparam int PD_W   = cnt_width(PD_CYCLES);
    localparam int FILT_W = cnt_width(LOCK_FILTER);
    localparam int TMO_W  = cnt_width(LOCK_TIMEOUT);

    localparam logic [PD_W-1:0]    PD_LAST   = PD_W'(PD_CYCLES - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic               r_sync_p0;
    logic               r_sync_p1;
    pll_state_t         r_state;
    logic [PD_W-1:0]    r_pd_cnt;
    logic [FILT_W-1:0]  r_filt_cnt;
    logic [TMO_W-1:0]   r_timer;
    logic [RETRY_W-1:0] r_retry;
    logic [LOSS_W-1:0]  r_loss_cnt;
    logic               r_powerdown_n;
    logic               r_locked;
    logic               r_fault;

    pll_state_t         w_state_nxt;
    pll_state_t         w_fail_state;
    logic [PD_W-1:0]    w_pd_cnt_nxt;
    logic [FILT_W-1:0]  w_filt_cnt_nxt;
    logic [TMO_W-1:0]   w_timer_nxt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [RETRY_W-1:0] w_retry_inc;
    logic [LOSS_W-1:0]  w_loss_cnt_nxt;
    logic               w_lock;
    logic               w_timeout;

    assign w_lock = r_sync_p1;

    always_comb begin
        w_state_nxt    = r_state;
        w_pd_cnt_nxt   = r_pd_cnt;
        w_filt_cnt_nxt = r_filt_cnt;
        w_timer_nxt    = r_timer;
        w_retry_nxt    = r_retry;
        w_loss_cnt_nxt = r_loss_cnt;
        w_retry_inc    = r_retry + RETRY_W'(1);
        w_timeout      = (r_timer == TMO_LAST);
        w_fail_state   = (w_retry_inc == RETRY_MAX) ? ST_FLT : ST_PWRDN;

        unique case (r_state)
            ST_PWRDN: begin
                // The powerdown counter saturates, so a late ENABLE starts at once.
                if (r_pd_cnt != PD_LAST) begin
                    w_pd_cnt_nxt = r_pd_cnt + PD_W'(1);
                end else if (i_enable) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_timer_nxt = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (!i_enable) begin
                    w_state_nxt  = ST_PWRDN;
                    w_pd_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_retry_nxt  = w_retry_inc;
                    w_state_nxt  = w_fail_state;
                    w_pd_cnt_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMO_W'(1);
                    if (w_lock) begin
                        w_state_nxt    = ST_FILTER;
                        w_filt_cnt_nxt = '0;
                    end
                end
            end
            ST_FILTER: begin
                if (!i_enable) begin
                    w_state_nxt  = ST_PWRDN;
                    w_pd_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_retry_nxt  = w_retry_inc;
                    w_state_nxt  = w_fail_state;
                    w_pd_cnt_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMO_W'(1);
                    if (!w_lock) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (r_filt_cnt == FILT_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_retry_nxt = '0;
                    end else begin
                        w_filt_cnt_nxt = r_filt_cnt + FILT_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (!i_enable) begin
                    w_state_nxt  = ST_PWRDN;
                    w_pd_cnt_nxt = '0;
                end else if (!w_lock) begin
                    w_loss_cnt_nxt = sat_inc_loss(r_loss_cnt);
                    w_state_nxt    = ST_PWRDN;
                    w_pd_cnt_nxt   = '0;
                end
            end
            ST_FLT: begin
                if (i_clear_fault) begin
                    w_state_nxt  = ST_PWRDN;
                    w_pd_cnt_nxt = '0;
                    w_retry_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt  = ST_PWRDN;
                w_pd_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave on a flop edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_p0     <= 1'b0;
            r_sync_p1     <= 1'b0;
            r_state       <= ST_PWRDN;
            r_pd_cnt      <= '0;
            r_filt_cnt    <= '0;
            r_timer       <= '0;
            r_retry       <= '0;
            r_loss_cnt    <= '0;
            r_powerdown_n <= 1'b0;
            r_locked      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_sync_p0     <= i_pll_lock;
            r_sync_p1     <= r_sync_p0;
            r_state       <= w_state_nxt;
            r_pd_cnt      <= w_pd_cnt_nxt;
            r_filt_cnt    <= w_filt_cnt_nxt;
            r_timer       <= w_timer_nxt;
            r_retry       <= w_retry_nxt;
            r_loss_cnt    <= w_loss_cnt_nxt;
            r_powerdown_n <= (w_state_nxt inside {ST_WAIT_LOCK, ST_FILTER, ST_LOCKED});
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_fault       <= (w_state_nxt == ST_FLT);
        end
    end

    assign o_powerdown_n = r_powerdown_n;
    assign o_locked      = r_locked;
    assign o_fault       = r_fault;
    assign o_loss_cnt    = r_loss_cnt;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervisor for up to eight CCC/PLL instances: one lock channel per PLL plus
// the registered aggregate lock that gates downstream reset release.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLL      = 2,
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_FILTER  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_PLL-1:0]        ENABLE,
    input  logic                      CLEAR_FAULT,
    input  logic [NUM_PLL-1:0]        PLL_LOCK,
    output logic [NUM_PLL-1:0]        PLL_POWERDOWN_N,
    output logic [NUM_PLL-1:0]        LOCKED,
    output logic [NUM_PLL-1:0]        FAULT,
    output logic                      ALL_LOCKED,
    output logic [LOSS_W*NUM_PLL-1:0] LOSS_CNT
);

    logic [NUM_PLL-1:0] w_powerdown_n;
    logic [NUM_PLL-1:0] w_locked;
    logic [NUM_PLL-1:0] w_fault;
    logic               r_all_locked;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
        pll_lock_channel #(
            .PD_CYCLES    (PD_CYCLES),
            .LOCK_FILTER  (LOCK_FILTER),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .MAX_RETRY    (MAX_RETRY)
        ) u_chan (
            .i_clk         (CLK),
            .i_rst         (RST),
            .i_enable      (ENABLE[g]),
            .i_clear_fault (CLEAR_FAULT),
            .i_pll_lock    (PLL_LOCK[g]),
            .o_powerdown_n (w_powerdown_n[g]),
            .o_locked      (w_locked[g]),
            .o_fault       (w_fault[g]),
            .o_loss_cnt    (LOSS_CNT[g*LOSS_W +: LOSS_W])
        );
    end

    // Disabled channels do not hold the aggregate off, but at least one must run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= (&(w_locked | ~ENABLE)) && (|ENABLE);
        end
    end

    assign PLL_POWERDOWN_N = w_powerdown_n;
    assign LOCKED          = w_locked;
    assign FAULT           = w_fault;
    assign ALL_LOCKED      = r_all_locked;

endmodule
